// File: rtl/dpram_pkg.sv
// Shared types and helpers for the dpram_pipe RAM and its reference models.
// Holds no logic of its own, so there is no latency or backpressure here.
package dpram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int DEF_DATA_W     = 32;
    localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

    // byte_merge works at a fixed maximum width; callers zero-extend and truncate.
    localparam int MERGE_W     = 256;
    localparam int MERGE_BYTES = MERGE_W / 8;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]     old_w,
        input logic [MERGE_W-1:0]     new_w,
        input logic [MERGE_BYTES-1:0] be
    );
        logic [MERGE_W-1:0] m;
        m = old_w;
        for (int b = 0; b < MERGE_BYTES; b++) begin
            if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// Read-return pipeline carrying data, valid and collision flag.
// Latency is RD_LAT cycles. There is no backpressure, and data holds while valid is low.
module dpram_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_i,
    input  logic              coll_i,
    input  logic [DATA_W-1:0] dat_i,
    output logic              vld_o,
    output logic              coll_o,
    output logic [DATA_W-1:0] dat_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] coll_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            coll_q <= '0;
            for (int s = 0; s < RD_LAT; s++) dat_q[s] <= '0;
        end else begin
            vld_q[0]  <= vld_i;
            coll_q[0] <= vld_i & coll_i;
            if (vld_i) dat_q[0] <= dat_i;
            // Each stage only reloads its data when a valid word moves in.
            for (int s = 1; s < RD_LAT; s++) begin
                vld_q[s]  <= vld_q[s-1];
                coll_q[s] <= coll_q[s-1];
                if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
            end
        end
    end

    assign vld_o  = vld_q[RD_LAT-1];
    assign coll_o = coll_q[RD_LAT-1];
    assign dat_o  = dat_q[RD_LAT-1];

endmodule

// File: rtl/dpram_pipe.sv
// Simple dual-port RAM with byte-enabled writes and a self-clearing sweep after reset.
// Read latency is RD_LAT, with a rd_valid strobe. No backpressure; requests are dropped while busy.
module dpram_pipe
    import dpram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   data_out,
    output logic                rd_valid,
    output logic                collision,
    output logic                busy
);

    localparam int BYTES = bytes_per_word(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
        $fatal(1, "dpram_pipe: RD_LAT must be 1 or 2");
    end
    if (DATA_W % 8 != 0 || DATA_W > MERGE_W) begin : g_bad_width
        $fatal(1, "dpram_pipe: DATA_W must be a multiple of 8 and at most MERGE_W");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              clr_we;
    logic              ready;
    logic              acc_wr;
    logic              acc_rd;
    logic              hit;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_dat;
    logic [MERGE_W-1:0]     old_ext, new_ext, merged_ext;
    logic [MERGE_BYTES-1:0] be_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == {ADDR_W{1'b1}}) state_d = READY;
            end
            default: state_d = state_q;
        endcase
    end

    // busy follows rst directly so it reads high even before the first reset edge.
    always_comb begin
        busy   = rst | (state_q == CLEAR);
        clr_we = ~rst & (state_q == CLEAR);
        ready  = ~rst & (state_q == READY);
    end

    assign acc_wr = wr_en & ready;
    assign acc_rd = rd_en & ready;
    assign hit    = acc_wr & acc_rd & (rd_addr == wr_addr);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (acc_wr) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_be[b]) mem_q[wr_addr][8*b +: 8] <= data_in[8*b +: 8];
            end
        end
    end

    // rd_word is the pre-write contents, which is already the read-first answer.
    assign rd_word = mem_q[rd_addr];

    always_comb begin
        old_ext = '0;
        new_ext = '0;
        be_ext  = '0;
        old_ext[DATA_W-1:0] = rd_word;
        new_ext[DATA_W-1:0] = data_in;
        be_ext[BYTES-1:0]   = wr_be;
        merged_ext = byte_merge(old_ext, new_ext, be_ext);
        rd_dat     = (hit && BYPASS != 0) ? merged_ext[DATA_W-1:0] : rd_word;
    end

    if (DATA_W < MERGE_W) begin : g_merge_tail
        logic unused_merge_tail;
        assign unused_merge_tail = ^merged_ext[MERGE_W-1:DATA_W];
    end

    dpram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (acc_rd),
        .coll_i (hit),
        .dat_i  (rd_dat),
        .vld_o  (rd_valid),
        .coll_o (collision),
        .dat_o  (data_out)
    );

endmodule

// File: tb/tb_dpram_pipe.sv
// Bench for dpram_pipe: one write-first RD_LAT=1 instance and one read-first RD_LAT=2 instance share stimulus.
module tb_dpram_pipe;
    import dpram_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, wr_en, rd_en;
    logic [3:0]  wr_addr, rd_addr, wr_be;
    logic [31:0] data_in;
    logic [31:0] dout_a, dout_b;
    logic        vld_a, vld_b, coll_a, coll_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dpram_pipe #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout_a),
        .rd_valid(vld_a), .collision(coll_a), .busy(busy_a));

    dpram_pipe #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout_b),
        .rd_valid(vld_b), .collision(coll_b), .busy(busy_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [MERGE_W-1:0] r;
        r = byte_merge({{(MERGE_W-32){1'b0}}, o}, {{(MERGE_W-32){1'b0}}, n},
                       {{(MERGE_BYTES-4){1'b0}}, be});
        return r[31:0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_be = 4'h0;
    endtask

    // One request cycle, then one idle cycle so the RD_LAT=2 instance can return.
    task automatic op(input logic we, input logic [3:0] wa, input logic [3:0] be, input logic [31:0] wd,
                      input logic re, input logic [3:0] ra,
                      input logic [31:0] exp_a, input logic [31:0] exp_b, input logic exp_coll);
        wr_en = we; wr_addr = wa; wr_be = be; data_in = wd;
        rd_en = re; rd_addr = ra;
        cyc();
        check("a_valid", {31'd0, vld_a}, {31'd0, re});
        check("b_valid_early", {31'd0, vld_b}, 32'd0);
        if (re) begin
            check("a_data", dout_a, exp_a);
            check("a_coll", {31'd0, coll_a}, {31'd0, exp_coll});
        end
        idle();
        cyc();
        check("b_valid", {31'd0, vld_b}, {31'd0, re});
        check("a_valid_drop", {31'd0, vld_a}, 32'd0);
        if (re) begin
            check("b_data", dout_b, exp_b);
            check("b_coll", {31'd0, coll_b}, {31'd0, exp_coll});
            check("a_data_hold", dout_a, exp_a);
        end
    endtask

    // Counts busy cycles after rst falls; a request pulse late in the sweep must be ignored.
    task automatic count_busy(output int na, output int nb, output int stray);
        na = 0; nb = 0; stray = 0;
        for (int i = 0; i < 24; i++) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            if (vld_a || vld_b) stray++;
            if (i == 13) begin
                wr_en = 1'b1; wr_addr = 4'h0; wr_be = 4'hF; data_in = 32'hFFFF_FFFF;
                rd_en = 1'b1; rd_addr = 4'h0;
            end else begin
                idle();
            end
            cyc();
        end
    endtask

    logic [31:0] mmem [DEPTH];
    int          busy_left, clr;
    logic        a_v, a_c, b1_v, b1_c, b_v, b_c, iv, ic;
    logic [31:0] a_d, b1_d, b_d, id_a, id_b;
    int          mcoll_a, mcoll_b, dcoll_a, dcoll_b;
    int          na, nb, stray;

    initial begin
        idle();
        rst = 1'b1; wr_addr = 4'h0; rd_addr = 4'h0; data_in = 32'h0;
        repeat (3) cyc();
        check("rst_busy_a", {31'd0, busy_a}, 32'd1);
        check("rst_busy_b", {31'd0, busy_b}, 32'd1);
        check("rst_vld_a", {31'd0, vld_a}, 32'd0);
        check("rst_vld_b", {31'd0, vld_b}, 32'd0);
        check("rst_dout_a", dout_a, 32'd0);
        check("rst_dout_b", dout_b, 32'd0);
        check("rst_coll_a", {31'd0, coll_a}, 32'd0);

        rst = 1'b0;
        count_busy(na, nb, stray);
        check("sweep_len_a", na, 32'd16);
        check("sweep_len_b", nb, 32'd16);
        check("sweep_no_valid", stray, 32'd0);

        for (int i = 0; i < DEPTH; i++) op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i), 32'h0, 32'h0, 1'b0);

        op(1'b1, 4'h3, 4'hF, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        op(1'b1, 4'h3, 4'h5, 32'h1122_3344, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h3, 32'hDE22_BE44, 32'hDE22_BE44, 1'b0);

        for (int i = 0; i < 3; i++) op(1'b1, 4'(5 + i), 4'hF, 32'hC0DE_0005 + 32'(i), 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                rd_en = 1'b1; rd_addr = 4'(5 + i);
            end else begin
                idle();
            end
            cyc();
            check("b2b_a_vld", {31'd0, vld_a}, {31'd0, (i < 3)});
            if (i < 3) check("b2b_a_data", dout_a, 32'hC0DE_0005 + 32'(i));
            check("b2b_b_vld", {31'd0, vld_b}, {31'd0, (i >= 1 && i < 4)});
            if (i >= 1 && i < 4) check("b2b_b_data", dout_b, 32'hC0DE_0004 + 32'(i));
        end

        op(1'b1, 4'h9, 4'hF, 32'hAAAA_AAAA, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        op(1'b1, 4'h9, 4'h3, 32'h5555_5555, 1'b1, 4'h9, 32'hAAAA_5555, 32'hAAAA_AAAA, 1'b1);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h9, 32'hAAAA_5555, 32'hAAAA_5555, 1'b0);
        op(1'b1, 4'h9, 4'h0, 32'hFFFF_FFFF, 1'b1, 4'h9, 32'hAAAA_5555, 32'hAAAA_5555, 1'b1);
        op(1'b1, 4'h8, 4'hF, 32'h1212_1212, 1'b1, 4'h9, 32'hAAAA_5555, 32'hAAAA_5555, 1'b0);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h8, 32'h1212_1212, 32'h1212_1212, 1'b0);

        op(1'b1, 4'hA, 4'hF, 32'h1234_5678, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'hA, 32'h1234_5678, 32'h1234_5678, 1'b0);
        rst = 1'b1; cyc(); rst = 1'b0;
        repeat (6) cyc();
        check("mid_sweep_busy", {31'd0, busy_a}, 32'd1);
        rst = 1'b1; cyc(); rst = 1'b0;
        count_busy(na, nb, stray);
        check("resweep_len_a", na, 32'd16);
        check("resweep_len_b", nb, 32'd16);
        check("resweep_no_valid", stray, 32'd0);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'hA, 32'h0, 32'h0, 1'b0);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h9, 32'h0, 32'h0, 1'b0);

        mcoll_a = 0; mcoll_b = 0; dcoll_a = 0; dcoll_b = 0;
        busy_left = 0; clr = 0;
        a_v = 0; a_c = 0; a_d = 0; b1_v = 0; b1_c = 0; b1_d = 0; b_v = 0; b_c = 0; b_d = 0;
        for (int n = 0; n < 2000; n++) begin
            if (n > 0) begin
                check("rnd_vld_a", {31'd0, vld_a}, {31'd0, a_v});
                check("rnd_dout_a", dout_a, a_d);
                check("rnd_coll_a", {31'd0, coll_a}, {31'd0, a_c});
                check("rnd_vld_b", {31'd0, vld_b}, {31'd0, b_v});
                check("rnd_dout_b", dout_b, b_d);
                check("rnd_coll_b", {31'd0, coll_b}, {31'd0, b_c});
                check("rnd_busy", {31'd0, busy_a}, {31'd0, (busy_left > 0)});
                if (vld_a && coll_a) dcoll_a++;
                if (vld_b && coll_b) dcoll_b++;
                if (a_v && a_c) mcoll_a++;
                if (b_v && b_c) mcoll_b++;
            end
            rst     = (n == 0 || n == 1000);
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 15));
            wr_be   = 4'($urandom_range(0, 15));
            data_in = $urandom;
            rd_en   = ($urandom_range(0, 9) < 6);
            rd_addr = $urandom_range(0, 1) ? wr_addr : 4'($urandom_range(0, 15));

            if (rst) begin
                busy_left = DEPTH; clr = 0;
                a_v = 0; a_c = 0; a_d = 0; b1_v = 0; b1_c = 0; b_v = 0; b_c = 0; b_d = 0;
            end else begin
                iv = 0; ic = 0; id_a = 0; id_b = 0;
                if (busy_left > 0) begin
                    mmem[clr] = 32'h0;
                    clr++;
                    busy_left--;
                end else begin
                    if (rd_en) begin
                        iv   = 1;
                        id_b = mmem[rd_addr];
                        ic   = wr_en && (wr_addr == rd_addr);
                        id_a = ic ? merge32(id_b, data_in, wr_be) : id_b;
                    end
                    if (wr_en) mmem[wr_addr] = merge32(mmem[wr_addr], data_in, wr_be);
                end
                b_v = b1_v; b_c = b1_c;
                if (b1_v) b_d = b1_d;
                b1_v = iv; b1_c = ic;
                if (iv) b1_d = id_b;
                a_v = iv; a_c = ic;
                if (iv) a_d = id_a;
            end
            cyc();
        end
        idle();
        check("coll_count_a", dcoll_a, mcoll_a);
        check("coll_count_b", dcoll_b, mcoll_b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
